// File: rtl/regfile_dump_reader.sv
// Debug readout engine: walks a register range through a spare read port and
// streams (index, value) beats on a valid/ready interface with a running XOR checksum.
module regfile_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   beat_count
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   BEAT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] raddr_q;      // doubles as the walk cursor
  logic [ADDR_W-1:0] last_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_reg_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] checksum_q;
  logic [ADDR_W:0]   beat_count_q;

  logic [ADDR_W-1:0] start_idx;
  logic [ADDR_W-1:0] eff_last;
  logic              empty_walk;
  logic [ADDR_W-1:0] raddr_d;

  // With zero skipped, a range ending at 0 really ends at the top index.
  always_comb begin
    start_idx  = (SKIP_ZERO && first_reg == '0) ? IDX_ONE : first_reg;
    eff_last   = (SKIP_ZERO && last_reg == '0) ? '1 : last_reg;
    empty_walk = SKIP_ZERO && first_reg == '0 && last_reg == '0;
    raddr_d    = raddr_q + IDX_ONE;
    if (SKIP_ZERO && raddr_d == '0) begin
      raddr_d = IDX_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      raddr_q      <= '0;
      last_q       <= '0;
      out_valid_q  <= 1'b0;
      out_reg_q    <= '0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      checksum_q   <= '0;
      beat_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        // Abort beats a same-cycle handshake: the pending beat is dropped uncounted.
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              raddr_q      <= start_idx;
              last_q       <= eff_last;
              checksum_q   <= '0;
              beat_count_q <= '0;
              busy_q       <= 1'b1;
              if (empty_walk) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_READ;
              end
            end
          end
          S_READ: begin
            out_data_q  <= rf_rdata;
            out_reg_q   <= raddr_q;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
          S_HOLD: begin
            if (out_valid_q && out_ready) begin
              checksum_q   <= checksum_q ^ out_data_q;
              beat_count_q <= beat_count_q + BEAT_ONE;
              out_valid_q  <= 1'b0;
              if (raddr_q == last_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                raddr_q <= raddr_d;
                state_q <= S_READ;
              end
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rf_raddr   = raddr_q;
  assign out_valid  = out_valid_q;
  assign out_reg    = out_reg_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign checksum   = checksum_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed and randomized dumps against a list-based model of the walk; two
// instances cover SKIP_ZERO off and on, sharing stimulus and the register array.
module tb_regfile_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready, sel;
  logic [AW-1:0] first_reg, last_reg;
  logic [DW-1:0] regs [NR];

  logic [AW-1:0] raddr0, raddr1, oreg0, oreg1;
  logic [DW-1:0] rdata0, rdata1, odata0, odata1, csum0, csum1;
  logic          v0, v1, busy0, busy1, done0, done1;
  logic [AW:0]   bc0, bc1;

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .rf_raddr(raddr0), .rf_rdata(rdata0),
    .out_valid(v0), .out_ready(out_ready), .out_reg(oreg0), .out_data(odata0),
    .busy(busy0), .done(done0), .checksum(csum0), .beat_count(bc0)
  );

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .rf_raddr(raddr1), .rf_rdata(rdata1),
    .out_valid(v1), .out_ready(out_ready), .out_reg(oreg1), .out_data(odata1),
    .busy(busy1), .done(done1), .checksum(csum1), .beat_count(bc1)
  );

  logic [AW-1:0] o_raddr, o_reg;
  logic [DW-1:0] o_data, o_csum;
  logic          o_v, o_busy, o_done;
  logic [AW:0]   o_bc;
  assign o_raddr = sel ? raddr1 : raddr0;
  assign o_reg   = sel ? oreg1  : oreg0;
  assign o_data  = sel ? odata1 : odata0;
  assign o_csum  = sel ? csum1  : csum0;
  assign o_v     = sel ? v1     : v0;
  assign o_busy  = sel ? busy1  : busy0;
  assign o_done  = sel ? done1  : done0;
  assign o_bc    = sel ? bc1    : bc0;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {45'd0, o_raddr, o_v, o_reg, o_busy, o_done, o_bc}, 64'd0);
    check({tag, "_data"}, {32'd0, o_data}, 64'd0);
    check({tag, "_csum"}, {32'd0, o_csum}, 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((busy0 || busy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Expected beats: indices first..last with wrap, minus 0 when skipped,
  // each carrying the register value as it stood when the dump began.
  task automatic run_dump(input string name, input int f, input int l, input bit skip,
                          input int stall_beat, input int abort_beat, input bit poke5);
    logic [AW-1:0] ei[$];
    logic [DW-1:0] ed[$];
    logic [DW-1:0] snap [NR];
    logic [DW-1:0] xor_exp;
    int idx, nb, cyc, stall_cnt, done_cyc, n_exp;
    bit aborted, poked;

    wait_idle();
    sel = skip;
    for (int i = 0; i < NR; i++) snap[i] = regs[i];
    idx = f;
    for (int k = 0; k < NR; k++) begin
      if (!(skip && idx == 0)) begin
        ei.push_back(idx[AW-1:0]);
        ed.push_back(snap[idx]);
      end
      if (idx == l) break;
      idx = (idx + 1) % NR;
    end
    n_exp = ei.size();
    xor_exp = '0; nb = 0; stall_cnt = 0; done_cyc = -1; aborted = 0; poked = 0;

    @(negedge clk);
    first_reg = f[AW-1:0];
    last_reg  = l[AW-1:0];
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({name, "_busy_after_start"}, {63'd0, o_busy}, 64'd1);

    while (cyc < 300) begin
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      out_ready = 1'b1;
      if (o_v) begin
        if (nb == abort_beat) begin
          abort = 1'b1;
          aborted = 1;
          @(negedge clk);
          abort = 1'b0;
          break;
        end
        if (nb == stall_beat && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
        end
        check({name, "_beat_in_range"}, {63'd0, (nb < n_exp)}, 64'd1);
        if (nb < n_exp) begin
          check({name, "_out_reg"}, {59'd0, o_reg}, {59'd0, ei[nb]});
          check({name, "_out_data"}, {32'd0, o_data}, {32'd0, ed[nb]});
        end
        if (poke5 && !poked && o_reg == 5) begin
          regs[5] = 32'hDEAD;
          poked = 1;
        end
        if (out_ready) begin
          if (nb < n_exp) xor_exp ^= ed[nb];
          nb++;
        end
      end
      @(negedge clk);
      cyc++;
    end

    if (aborted) begin
      check({name, "_abort_valid"}, {63'd0, o_v}, 64'd0);
      check({name, "_abort_busy"}, {63'd0, o_busy}, 64'd0);
      check({name, "_abort_bc"}, {58'd0, o_bc}, abort_beat);
      check({name, "_abort_csum"}, {32'd0, o_csum}, {32'd0, xor_exp});
      for (int k = 0; k < 3; k++) begin
        check({name, "_abort_no_done"}, {63'd0, o_done}, 64'd0);
        @(negedge clk);
      end
    end else begin
      check({name, "_done_cycle"}, done_cyc, 2 * n_exp + 1 + stall_cnt);
      check({name, "_beats_seen"}, nb, n_exp);
      check({name, "_beat_count"}, {58'd0, o_bc}, n_exp);
      check({name, "_checksum"}, {32'd0, o_csum}, {32'd0, xor_exp});
      @(negedge clk);
      check({name, "_done_pulse"}, {63'd0, o_done}, 64'd0);
      check({name, "_busy_clear"}, {63'd0, o_busy}, 64'd0);
      check({name, "_checksum_hold"}, {32'd0, o_csum}, {32'd0, xor_exp});
    end
    $display("dump %s first=%0d last=%0d skip=%0d beats=%0d done_cycle=%0d aborted=%0d",
             name, f, l, skip, nb, done_cyc, aborted);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; sel = 1'b0;
    first_reg = '0; last_reg = '0;
    for (int i = 0; i < NR; i++) regs[i] = i * 3;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset0");
    sel = 1'b1;
    check_all_zero("reset1");
    rst = 1'b0;
    @(negedge clk);

    run_dump("full",  0, 31, 1'b0, -1, -1, 1'b0);
    run_dump("wrap", 30,  1, 1'b0, -1, -1, 1'b0);
    run_dump("stall", 0, 31, 1'b0,  1, -1, 1'b0);
    run_dump("skip",  0,  3, 1'b1, -1, -1, 1'b0);
    run_dump("skip_empty", 0, 0, 1'b1, -1, -1, 1'b0);
    run_dump("single", 7, 7, 1'b0, -1, -1, 1'b0);
    run_dump("poke",  0, 31, 1'b0, -1, -1, 1'b1);
    run_dump("after_poke", 5, 5, 1'b0, -1, -1, 1'b0);
    run_dump("abort", 0, 31, 1'b0, -1,  3, 1'b0);

    // Reset in the middle of a dump clears everything without a clock edge.
    wait_idle();
    sel = 1'b0;
    @(negedge clk);
    first_reg = '0; last_reg = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("middump_busy", {63'd0, o_busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("middump_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      run_dump($sformatf("rand%0d", t), $urandom_range(0, 31), $urandom_range(0, 31),
               1'(t % 2), $urandom_range(0, 3), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/readout engine that walks a range of architectural registers through a spare register-file read port and streams each (index, value) pair out on a valid/ready interface.
- Sits beside the register file in the mini-MIPS core. It drives the read address and consumes the combinational read data.
- Used by the testbench and debug logic to snapshot register state without stalling the write path.
- Also produces a running XOR checksum and a beat count for quick comparison against a golden model.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width (NUM_REGS = 2**ADDR_W)
SKIP_ZERO, 0, when 1, index 0 is not emitted (hardwired zero register)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a dump; sampled only in IDLE
abort  input  1  terminate the dump in progress; no done pulse
first_reg  input  ADDR_W  first index to read, latched on start
last_reg  input  ADDR_W  last index to read, latched on start
rf_raddr  output  ADDR_W  address to the register-file read port (registered)
rf_rdata  input  DATA_W  combinational read data for rf_raddr
out_valid  output  1  out_reg/out_data hold a beat
out_ready  input  1  sink accepts the beat
out_reg  output  ADDR_W  index of the current beat
out_data  output  DATA_W  value of the current beat
busy  output  1  high from start acceptance until DONE is left
done  output  1  one-cycle pulse at normal completion
checksum  output  DATA_W  XOR of all accepted out_data since the last start
beat_count  output  ADDR_W+1  number of accepted beats since the last start

Behaviour:
- Reset (async): state=IDLE. All outputs are 0: rf_raddr, out_valid, out_reg, out_data, busy, done, checksum, beat_count.
- FSM states: IDLE, READ, HOLD, DONE.
- IDLE, start=1:
  - latch first_reg/last_reg; cur<=first_reg; rf_raddr<=first_reg.
  - clear checksum and beat_count; busy<=1; go to READ.
  - If SKIP_ZERO=1 and first_reg=0, cur starts at 1. If first_reg=last_reg=0 with SKIP_ZERO=1, go straight to DONE with zero beats.
- READ, one cycle:
  - rf_raddr=cur, so rf_rdata is valid this cycle.
  - out_data<=rf_rdata; out_reg<=cur; out_valid<=1; go to HOLD.
- HOLD:
  - out_valid=1. out_reg/out_data stay stable until out_valid&&out_ready.
  - On handshake: checksum<=checksum^out_data; beat_count<=beat_count+1; out_valid<=0.
  - On handshake, if cur==last: go to DONE.
  - Otherwise: cur<=cur+1 modulo 2**ADDR_W (skipping 0 if SKIP_ZERO); rf_raddr<=next cur; go to READ.
- DONE, one cycle: done=1, busy<=0, then IDLE. checksum and beat_count hold until the next start.
- Throughput: at most one beat per 2 cycles. A dump of N registers with out_ready tied high has done asserted in cycle 2N+1 after the start-accept edge.
- Wrap-around: if last_reg<first_reg, the walk runs first..31 then 0..last. first==last gives exactly one beat.
- The value is captured in the READ cycle. A register-file write to the same index later does not change the beat in flight. A write on the READ cycle edge returns the old value, because the register file updates on the edge.
- start while busy is ignored.
- abort (any non-IDLE state): next state is IDLE. out_valid<=0, busy<=0, no done pulse. checksum/beat_count keep their partial values. abort has priority over a handshake in the same cycle; that beat is not counted.
- rst mid-dump: immediate return to reset values.

Test Plan:
- Registers preloaded with reg[i]=i*3; start with first=0, last=31, out_ready=1 -> 32 beats with out_reg 0..31 and out_data 0,3,...,93; done in cycle 65; beat_count=32; checksum = XOR of i*3.
- first=30, last=1 (wrap) -> beats for indices 30,31,0,1 in order; beat_count=4.
- Run with out_ready low for 5 cycles on beat 2 -> out_valid stays high and out_reg/out_data stay constant for those cycles; there is no duplicate and no skipped beat; total beats unchanged.
- SKIP_ZERO=1, first=0, last=3 -> beats for 1,2,3 only; beat_count=3. Then first=last=0 -> done one cycle after start, 0 beats.
- Register-file write to reg 5 (value 0xDEAD) on the cycle after reg 5 is read -> the emitted beat carries the old value; a second dump shows 0xDEAD.
- abort asserted during beat 4 of a 0..31 dump -> out_valid drops next cycle, busy=0, no done, beat_count=3. rst asserted mid-dump -> all outputs 0 asynchronously.
